// File: rtl/ins_loader_pkg.sv
// Shared constants and the loader FSM state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ins_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam int        HDR_BYTES  = 2;
  localparam int        WORD_BYTES = 4;
  localparam logic [7:0] CHK_INIT  = 8'h00;

endpackage

// File: rtl/ins_loader_byte_packer.sv
// Packs stream bytes into a big-endian 32-bit word and keeps the running XOR checksum.
// Latency: word/checksum registers update on the edge of each shift; full is combinational.
// Backpressure: none of its own; the caller gates shift_en with the byte handshake.
//
// Ports: CLK/RST clock and async active-high reset; clr restarts word, index and
// checksum; shift_en shifts ByteIn in; word is the packed register, byte_idx the
// slot the next byte lands in, full flags the 4th shift, chk the XOR of all shifts.
module byte_packer
  import ins_loader_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  ByteIn,
  output logic [31:0] word,
  output logic [1:0]  byte_idx,
  output logic        full,
  output logic [7:0]  chk
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;
  logic [7:0]  chk_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_q <= '0;
      idx_q  <= '0;
      chk_q  <= CHK_INIT;
    end else if (clr) begin
      word_q <= '0;
      idx_q  <= '0;
      chk_q  <= CHK_INIT;
    end else if (shift_en) begin
      // First byte of a word ends up in [31:24] after four shifts.
      word_q <= {word_q[23:0], ByteIn};
      idx_q  <= idx_q + 2'd1;   // wraps back to slot 0 after the 4th byte
      chk_q  <= chk_q ^ ByteIn;
    end
  end

  assign word     = word_q;
  assign byte_idx = idx_q;
  assign full     = shift_en && (idx_q == 2'(WORD_BYTES - 1));
  assign chk      = chk_q;

endmodule

// File: rtl/ins_loader.sv
// Program loader: length header + big-endian words + XOR checksum -> instruction memory writes, then CPU release.
// Latency: one WRITE cycle after the 4th byte of each word; 5 cycles/word minimum.
// Backpressure: ByteReady low outside LEN_HI/LEN_LO/DATA/CHECK (notably in WRITE); ByteValid gaps stall without loss.
//
// Ports: CLK/RST clock and async active-high reset; Start begins a load from
// IDLE/DONE/ERROR; ByteIn/ByteValid/ByteReady byte stream handshake;
// InsAddr/InsData/InsWE instruction memory write port; PC_Value CPU start PC;
// CPURun CPU release; Busy/Done/Error status; WordCount words written so far.
module ins_loader
  import ins_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_WORDS = 64,
  parameter int          CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [7:0]       ByteIn,
  input  logic             ByteValid,
  output logic             ByteReady,
  output logic [31:0]      InsAddr,
  output logic [31:0]      InsData,
  output logic             InsWE,
  output logic [31:0]      PC_Value,
  output logic             CPURun,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [CNT_W-1:0] WordCount
);

  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WORDS);

  state_t           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] wc_q;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  logic             we_q;
  logic             done_q;
  logic             err_q;
  logic             run_q;

  logic             accept;
  logic             start_ok;
  logic [CNT_W-1:0] len_d;
  logic             len_bad;
  logic [CNT_W-1:0] wc_d;

  logic [31:0]      pk_word;
  logic [1:0]       pk_idx;
  logic             pk_full;
  logic [7:0]       pk_chk;

  assign ByteReady = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CHECK);
  assign Busy      = ByteReady || (state_q == S_WRITE);
  assign accept    = ByteValid && ByteReady;
  assign start_ok  = Start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                               (state_q == S_ERROR));

  assign len_d   = {len_q[CNT_W-1:8], ByteIn};
  assign len_bad = (len_d == '0) || (len_d > MAX_W);
  assign wc_d    = wc_q + 1'b1;

  byte_packer u_packer (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (start_ok),
    .shift_en (accept && (state_q == S_DATA)),
    .ByteIn   (ByteIn),
    .word     (pk_word),
    .byte_idx (pk_idx),
    .full     (pk_full),
    .chk      (pk_chk)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wc_q    <= '0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (Start) begin
            state_q <= S_LEN_HI;
            len_q   <= '0;
            wc_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_q[CNT_W-1:8] <= ByteIn;
            state_q          <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len_q <= len_d;
            if (len_bad) begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
              run_q   <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          // The write strobe, data and address are registered here so they
          // are all valid during the single WRITE cycle.
          if (pk_full) begin
            state_q <= S_WRITE;
            we_q    <= 1'b1;
            data_q  <= {pk_word[23:0], ByteIn};
            addr_q  <= BASE_ADDR + (32'(wc_q) << 2);
          end
        end
        S_WRITE: begin
          wc_q    <= wc_d;
          state_q <= (wc_d == len_q) ? S_CHECK : S_DATA;
        end
        S_CHECK: begin
          if (accept) begin
            // A load can only reach CHECK on a word boundary; requiring slot 0
            // keeps a desynchronised packer from ever signalling a clean load.
            if ((ByteIn == pk_chk) && (pk_idx == 2'd0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              run_q   <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
              run_q   <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign InsAddr   = addr_q;
  assign InsData   = data_q;
  assign InsWE     = we_q;
  assign PC_Value  = BASE_ADDR;
  assign CPURun    = run_q;
  assign Done      = done_q;
  assign Error     = err_q;
  assign WordCount = wc_q;

endmodule
